pipe_ctrl_fsm: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Inputs:
  - Hazard-detection result: load-use.
  - EX-stage branch redirect.
  - Data-memory ready handshake.
  - Start/done handshake of the iterative mul/div unit.
- Produces per-stage register enables, flush strobes and the mul/div start pulse.
- Sits beside the forwarding/hazard logic and drives every pipeline register.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipe_perf_cnt.sv | 28 ++
 rtl/pipe_ctrl_fsm.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_fsm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings, the bubble instruction and the default mul/div watchdog limit.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_HOLD = 2'd2
  } ctrl_state_e;

  // Canonical NOP (addi x0, x0, 0) loaded into a flushed pipeline register.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned MD_TIMEOUT_DEF = 64;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Three free-running wrap-around performance counters, each advanced by a
// single-cycle increment strobe; cleared by the synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             md_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] md_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      md_cnt    <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      if (md_inc)    md_cnt    <= md_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             redirect,
  input  logic             ex_is_md,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_start,
  output logic             md_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] md_cnt
);

  localparam int unsigned WD_LAST_I = (MD_TIMEOUT == 0) ? 0 : MD_TIMEOUT - 1;
  localparam int unsigned WD_W      = (WD_LAST_I > 0) ? $clog2(WD_LAST_I + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_LAST_I[WD_W-1:0];

  ctrl_state_e     state, next_state;
  logic [WD_W-1:0] wd_cnt;
  logic            mem_stall;
  logic            wd_expired;
  logic            wd_fire;

  assign mem_stall  = dmem_req & ~dmem_ready;
  assign wd_expired = (MD_TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign ctrl_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      md_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (wd_fire) md_timeout <= 1'b1;
    end
  end

  // Watchdog saturates at its limit so a memory freeze cannot wrap it;
  // it restarts whenever MD_WAIT is left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == MD_WAIT && next_state == MD_WAIT) begin
      if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  always_comb begin
    next_state   = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;
    wd_fire      = 1'b0;

    if (!rst_n) begin
      next_state = RUN;
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      if (state == MD_WAIT && md_done) next_state = MD_HOLD;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_is_md) begin
            md_start     = 1'b1;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            next_state   = MD_WAIT;
          end else if (redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            next_state = RUN;
          end else if (wd_expired) begin
            // Abort: drop the mul/div in EX and hold ID behind a bubble.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            wd_fire      = 1'b1;
            next_state   = RUN;
          end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end
        MD_HOLD: begin
          next_state = RUN;
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc, flush_inc, md_inc;

  assign stall_inc = ~pc_en;
  assign flush_inc = if_id_flush | id_ex_flush | ex_mem_flush;
  assign md_inc    = (state == MD_WAIT) || (state == MD_HOLD);

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall_inc (stall_inc),
    .flush_inc (flush_inc),
    .md_inc    (md_inc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .md_cnt    (md_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign md_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed self-checking bench for pipe_ctrl_fsm (watchdog limit 8);
// counter expectations follow whether PIPE_PERF_CNT_EN is defined.
module tb_pipe_ctrl_fsm;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, load_use_hazard, redirect, ex_is_md, md_done, dmem_req, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_start, md_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt, flush_cnt, md_cnt;
  logic [4:0]  en;
  logic [2:0]  fl;
  logic [31:0] exp_c;

  int checks = 0;
  int errors = 0;

  assign en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  assign fl = {if_id_flush, id_ex_flush, ex_mem_flush};

  always #5 clk = ~clk;

  pipe_ctrl_fsm #(
    .MD_TIMEOUT (8),
    .CNT_W      (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_use_hazard (load_use_hazard),
    .redirect        (redirect),
    .ex_is_md        (ex_is_md),
    .md_done         (md_done),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .md_start        (md_start),
    .md_timeout      (md_timeout),
    .ctrl_state      (ctrl_state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .md_cnt          (md_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    load_use_hazard = 1'b0; redirect = 1'b0; ex_is_md = 1'b0;
    md_done = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL rst_en got %b exp 11111", en); end
    checks++; if ({fl, md_start} !== 4'b0000) begin errors++; $display("FAIL rst_fl got %b exp 0000", {fl, md_start}); end
    rst_n = 1'b1;
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL idle_state got %0d exp 0", ctrl_state); end
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL idle_en got %b exp 11111", en); end
    checks++; if (fl !== 3'b000) begin errors++; $display("FAIL idle_fl got %b exp 000", fl); end
    checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL idle_to got %b exp 0", md_timeout); end
    checks++; if ({stall_cnt, flush_cnt, md_cnt} !== 96'd0) begin errors++; $display("FAIL idle_cnt got %0d %0d %0d exp 0 0 0", stall_cnt, flush_cnt, md_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    load_use_hazard = 1'b1;
    #1;
    checks++; if (en !== 5'b00111) begin errors++; $display("FAIL lu_en got %b exp 00111", en); end
    checks++; if (fl !== 3'b010) begin errors++; $display("FAIL lu_fl got %b exp 010", fl); end
    tick();
    load_use_hazard = 1'b0;
    #1;
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL lu_after_en got %b exp 11111", en); end
    exp_c = PERF_ON ? 32'd1 : 32'd0;
    checks++; if (stall_cnt !== exp_c) begin errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, exp_c); end
  endtask

  task automatic test_redirect();
    do_reset();
    redirect = 1'b1;
    load_use_hazard = 1'b1;
    #1;
    checks++; if (en !== 5'b11111) begin errors++; $display("FAIL rd_en got %b exp 11111", en); end
    checks++; if (fl !== 3'b110) begin errors++; $display("FAIL rd_fl got %b exp 110", fl); end
    tick();
    clear_inputs();
    #1;
    exp_c = PERF_ON ? 32'd1 : 32'd0;
    checks++; if (flush_cnt !== exp_c) begin errors++; $display("FAIL rd_flush_cnt got %0d exp %0d", flush_cnt, exp_c); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rd_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_md();
    do_reset();
    ex_is_md = 1'b1;
    #1;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL md_start got %b exp 1", md_start); end
    checks++; if (en !== 5'b00011 || fl !== 3'b001) begin errors++; $display("FAIL md_issue got %b/%b exp 00011/001", en, fl); end
    tick();
    ex_is_md = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      checks++; if ({ctrl_state, md_start} !== 3'b010) begin errors++; $display("FAIL md_wait%0d got %b exp 010", i, {ctrl_state, md_start}); end
      checks++; if (en !== 5'b00011 || fl !== 3'b001) begin errors++; $display("FAIL md_wait_ctl%0d got %b/%b exp 00011/001", i, en, fl); end
      tick();
    end
    md_done = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL md_done got %b/%b exp 11111/000", en, fl); end
    tick();
    md_done = 1'b0;
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL md_ret got %0d exp 0", ctrl_state); end
    exp_c = PERF_ON ? 32'd5 : 32'd0;
    checks++; if (stall_cnt !== exp_c) begin errors++; $display("FAIL md_stall_cnt got %0d exp %0d", stall_cnt, exp_c); end
    checks++; if (flush_cnt !== exp_c) begin errors++; $display("FAIL md_flush_cnt got %0d exp %0d", flush_cnt, exp_c); end
    checks++; if (md_cnt !== exp_c) begin errors++; $display("FAIL md_cnt got %0d exp %0d", md_cnt, exp_c); end
  endtask

  task automatic test_md_hold();
    do_reset();
    ex_is_md = 1'b1;
    tick();
    ex_is_md = 1'b0;
    md_done = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++; if (en !== 5'b00000 || fl !== 3'b000) begin errors++; $display("FAIL hd_done_frz got %b/%b exp 00000/000", en, fl); end
    tick();
    md_done = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctrl_state !== 2'd2) begin errors++; $display("FAIL hd_state%0d got %0d exp 2", i, ctrl_state); end
      checks++; if (en !== 5'b00000) begin errors++; $display("FAIL hd_frz%0d got %b exp 00000", i, en); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl_state !== 2'd2 || en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL hd_rel got %0d/%b/%b exp 2/11111/000", ctrl_state, en, fl); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL hd_ret got %0d exp 0", ctrl_state); end
    exp_c = PERF_ON ? 32'd4 : 32'd0;
    checks++; if (stall_cnt !== exp_c) begin errors++; $display("FAIL hd_stall_cnt got %0d exp %0d", stall_cnt, exp_c); end
    checks++; if (md_cnt !== exp_c) begin errors++; $display("FAIL hd_md_cnt got %0d exp %0d", md_cnt, exp_c); end
    exp_c = PERF_ON ? 32'd1 : 32'd0;
    checks++; if (flush_cnt !== exp_c) begin errors++; $display("FAIL hd_flush_cnt got %0d exp %0d", flush_cnt, exp_c); end
  endtask

  task automatic test_mem_stall();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_is_md = 1'b1; redirect = 1'b1;
    #1;
    checks++; if (en !== 5'b00000 || fl !== 3'b000 || md_start !== 1'b0) begin errors++; $display("FAIL ms_frz got %b/%b/%b exp 00000/000/0", en, fl, md_start); end
    tick();
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL ms_state got %0d exp 0", ctrl_state); end
    dmem_ready = 1'b1;
    #1;
    checks++; if (md_start !== 1'b1) begin errors++; $display("FAIL ms_start got %b exp 1", md_start); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ctrl_state !== 2'd1) begin errors++; $display("FAIL ms_wait got %0d exp 1", ctrl_state); end
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 3'b000) begin errors++; $display("FAIL mid_rst got %b/%b exp 11111/000", en, fl); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ctrl_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", ctrl_state); end
  endtask

  task automatic test_timeout();
    do_reset();
    ex_is_md = 1'b1;
    tick();
    ex_is_md = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      #1;
      checks++; if ({ctrl_state, md_timeout, fl} !== 6'b010_001) begin errors++; $display("FAIL to_wait%0d got %b exp 010001", i, {ctrl_state, md_timeout, fl}); end
      tick();
    end
    #1;
    checks++; if (fl !== 3'b011) begin errors++; $display("FAIL to_fl got %b exp 011", fl); end
    tick();
    checks++; if (ctrl_state !== 2'd0 || md_timeout !== 1'b1) begin errors++; $display("FAIL to_fire got %0d/%b exp 0/1", ctrl_state, md_timeout); end
    tick();
    tick();
    checks++; if (md_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", md_timeout); end
    exp_c = PERF_ON ? 32'd9 : 32'd0;
    checks++; if (stall_cnt !== exp_c) begin errors++; $display("FAIL to_stall_cnt got %0d exp %0d", stall_cnt, exp_c); end
    exp_c = PERF_ON ? 32'd8 : 32'd0;
    checks++; if (md_cnt !== exp_c) begin errors++; $display("FAIL to_md_cnt got %0d exp %0d", md_cnt, exp_c); end
    do_reset();
    checks++; if (md_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b exp 0", md_timeout); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_md();
    test_md_hold();
    test_mem_stall();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
